vga_timing: RTL and testbench

Generates raster timing for a 640x480 @ 60 Hz VGA display from the board system clock. It produces pixel coordinates, a blanking flag and the horizontal/vertical sync pulses. The pixel-colour pattern generator consumes the coordinate and blank outputs. The sync outputs drive the VGA connector pins directly. All timing outputs are registered and mutually coherent, so every output describes the same pixel in the same clock cycle.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_clk_div_tick.sv | 31 +++
 rtl/vga_timing.sv | 96 +++++++++
 tb/tb_vga_timing.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants, coordinate type and colour constants for the VGA
// raster generator and the pattern generator that consumes its outputs.
package vga_pkg;

   localparam int COORD_W = 11;

   localparam int DEF_CLK_DIV   = 2;
   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam rgb_t RGB_WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
   localparam rgb_t RGB_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
   localparam rgb_t RGB_BLUE  = '{r: 8'h00, g: 8'h00, b: 8'hFF};

   // True when lo <= v < lo + len.
   function automatic logic in_window(input coord_t v, input int lo, input int len);
      return (int'(v) >= lo) && (int'(v) < lo + len);
   endfunction

endpackage

// File: rtl/vga_clk_div_tick.sv
// Free-running clock-enable divider: tick is high for one clk in every CLK_DIV.
// With CLK_DIV = 1 the counter stays at zero and tick is permanently high.
module clk_div_tick #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/vga_timing.sv
// 640x480@60 raster timing: pixel counters plus registered blank/sync decode,
// all loaded from the next counter values so every output describes one pixel.
module vga_timing
   import vga_pkg::*;
#(
   parameter int CLK_DIV     = DEF_CLK_DIV,
   parameter int H_VISIBLE   = DEF_H_VISIBLE,
   parameter int H_FRONT     = DEF_H_FRONT,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BACK      = DEF_H_BACK,
   parameter int V_VISIBLE   = DEF_V_VISIBLE,
   parameter int V_FRONT     = DEF_V_FRONT,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BACK      = DEF_V_BACK,
   parameter bit SYNC_ACTIVE = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [COORD_W-1:0] hcount,
   output logic [COORD_W-1:0] vcount,
   output logic               blank,
   output logic               hsync,
   output logic               vsync,
   output logic               pix_tick,
   output logic               frame_start
);

   localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam coord_t H_LAST = coord_t'(H_TOT - 1);
   localparam coord_t V_LAST = coord_t'(V_TOT - 1);

   logic   adv;
   coord_t hcount_q, hcount_d;
   coord_t vcount_q, vcount_d;
   logic   blank_q, blank_d;
   logic   hsync_q, hsync_d;
   logic   vsync_q, vsync_d;
   logic   pix_tick_q;
   logic   frame_start_q, frame_start_d;

   clk_div_tick #(
      .CLK_DIV(CLK_DIV)
   ) u_div (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (adv)
   );

   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (adv) begin
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
         end else begin
            hcount_d = hcount_q + 1'b1;
         end
      end
      // Decode from the next counts so the flags land in the same cycle as the counters.
      blank_d       = (int'(hcount_d) >= H_VISIBLE) || (int'(vcount_d) >= V_VISIBLE);
      hsync_d       = in_window(hcount_d, H_VISIBLE + H_FRONT, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d       = in_window(vcount_d, V_VISIBLE + V_FRONT, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      frame_start_d = adv && (hcount_d == '0) && (vcount_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         blank_q       <= 1'b0;
         hsync_q       <= ~SYNC_ACTIVE;
         vsync_q       <= ~SYNC_ACTIVE;
         pix_tick_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         blank_q       <= blank_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         pix_tick_q    <= adv;
         frame_start_q <= frame_start_d;
      end
   end

   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign blank       = blank_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign pix_tick    = pix_tick_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default-parameter instance for pixel rate, hsync and
// line wrap, and a shrunken CLK_DIV=1 instance for vsync, frame wrap and reset.
module tb_vga_timing;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [10:0] d0_h, d0_v, d1_h, d1_v;
   logic        d0_b, d0_hs, d0_vs, d0_pt, d0_fs;
   logic        d1_b, d1_hs, d1_vs, d1_pt, d1_fs;

   vga_timing u_dut0 (
      .clk(clk), .rst_n(rst_n), .hcount(d0_h), .vcount(d0_v), .blank(d0_b),
      .hsync(d0_hs), .vsync(d0_vs), .pix_tick(d0_pt), .frame_start(d0_fs)
   );

   // 24 x 15 raster: hsync at h 18..21, vsync at v 10..11, frame = 360 clks.
   vga_timing #(
      .CLK_DIV(1), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
      .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE(1'b0)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .hcount(d1_h), .vcount(d1_v), .blank(d1_b),
      .hsync(d1_hs), .vsync(d1_vs), .pix_tick(d1_pt), .frame_start(d1_fs)
   );

   typedef struct {
      int edge_n;
      int h;
      int v;
      int blank;
      int hs;
      int vs;
      int pix;
      int fs;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   int   edges = 0;
   vec_t vec0[15];
   vec_t vec1[19];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance to the given clk edge count since release, then sample 1 time unit later.
   task automatic step_to(input int target);
      while (edges < target) begin
         @(posedge clk);
         edges++;
      end
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_d0_h"},  d0_h,  0); chk({tag, "_d0_v"},  d0_v,  0);
      chk({tag, "_d0_b"},  d0_b,  0); chk({tag, "_d0_hs"}, d0_hs, 1);
      chk({tag, "_d0_vs"}, d0_vs, 1); chk({tag, "_d0_pt"}, d0_pt, 0);
      chk({tag, "_d0_fs"}, d0_fs, 0);
      chk({tag, "_d1_h"},  d1_h,  0); chk({tag, "_d1_v"},  d1_v,  0);
      chk({tag, "_d1_b"},  d1_b,  0); chk({tag, "_d1_hs"}, d1_hs, 1);
      chk({tag, "_d1_vs"}, d1_vs, 1); chk({tag, "_d1_pt"}, d1_pt, 0);
      chk({tag, "_d1_fs"}, d1_fs, 0);
      $display("reset check %s done", tag);
   endtask

   task automatic apply(input vec_t t, input int sel);
      int h, v, b, hs, vs, pt, fs;
      string p;
      step_to(t.edge_n);
      if (sel == 0) begin
         h = d0_h; v = d0_v; b = d0_b; hs = d0_hs; vs = d0_vs; pt = d0_pt; fs = d0_fs;
      end else begin
         h = d1_h; v = d1_v; b = d1_b; hs = d1_hs; vs = d1_vs; pt = d1_pt; fs = d1_fs;
      end
      p = $sformatf("d%0d_e%0d", sel, t.edge_n);
      chk({p, "_hcount"}, h, t.h);
      chk({p, "_vcount"}, v, t.v);
      chk({p, "_blank"}, b, t.blank);
      chk({p, "_hsync"}, hs, t.hs);
      chk({p, "_vsync"}, vs, t.vs);
      chk({p, "_pix_tick"}, pt, t.pix);
      chk({p, "_frame_start"}, fs, t.fs);
      $display("vec %s h=%0d v=%0d blank=%0d hs=%0d vs=%0d pt=%0d fs=%0d", p, h, v, b, hs, vs, pt, fs);
   endtask

   // Release reset midway between clk edges; the next posedge is edge 1.
   task automatic release_reset();
      #3;
      rst_n = 1'b1;
      edges = 0;
   endtask

   initial begin
      int hs_low, hs_err, vs_low, fs_cnt, fs_at, pt_err, found;

      //            edge   h    v  blk hs vs pt fs
      vec0[0]  = '{    1,   0,  0, 0, 1, 1, 0, 0};
      vec0[1]  = '{    2,   1,  0, 0, 1, 1, 1, 0};
      vec0[2]  = '{    3,   1,  0, 0, 1, 1, 0, 0};
      vec0[3]  = '{    4,   2,  0, 0, 1, 1, 1, 0};
      vec0[4]  = '{ 1279, 639,  0, 0, 1, 1, 0, 0};
      vec0[5]  = '{ 1280, 640,  0, 1, 1, 1, 1, 0};
      vec0[6]  = '{ 1311, 655,  0, 1, 1, 1, 0, 0};
      vec0[7]  = '{ 1312, 656,  0, 1, 0, 1, 1, 0};
      vec0[8]  = '{ 1503, 751,  0, 1, 0, 1, 0, 0};
      vec0[9]  = '{ 1504, 752,  0, 1, 1, 1, 1, 0};
      vec0[10] = '{ 1599, 799,  0, 1, 1, 1, 0, 0};
      vec0[11] = '{ 1600,   0,  1, 0, 1, 1, 1, 0};
      vec0[12] = '{15998, 799,  9, 1, 1, 1, 1, 0};
      vec0[13] = '{16000,   0, 10, 0, 1, 1, 1, 0};
      vec0[14] = '{16001,   0, 10, 0, 1, 1, 0, 0};

      vec1[0]  = '{  1,  1,  0, 0, 1, 1, 1, 0};
      vec1[1]  = '{  2,  2,  0, 0, 1, 1, 1, 0};
      vec1[2]  = '{ 15, 15,  0, 0, 1, 1, 1, 0};
      vec1[3]  = '{ 16, 16,  0, 1, 1, 1, 1, 0};
      vec1[4]  = '{ 17, 17,  0, 1, 1, 1, 1, 0};
      vec1[5]  = '{ 18, 18,  0, 1, 0, 1, 1, 0};
      vec1[6]  = '{ 21, 21,  0, 1, 0, 1, 1, 0};
      vec1[7]  = '{ 22, 22,  0, 1, 1, 1, 1, 0};
      vec1[8]  = '{ 23, 23,  0, 1, 1, 1, 1, 0};
      vec1[9]  = '{ 24,  0,  1, 0, 1, 1, 1, 0};
      vec1[10] = '{191, 23,  7, 1, 1, 1, 1, 0};
      vec1[11] = '{192,  0,  8, 1, 1, 1, 1, 0};
      vec1[12] = '{239, 23,  9, 1, 1, 1, 1, 0};
      vec1[13] = '{240,  0, 10, 1, 1, 0, 1, 0};
      vec1[14] = '{287, 23, 11, 1, 1, 0, 1, 0};
      vec1[15] = '{288,  0, 12, 1, 1, 1, 1, 0};
      vec1[16] = '{359, 23, 14, 1, 1, 1, 1, 0};
      vec1[17] = '{360,  0,  0, 0, 1, 1, 1, 1};
      vec1[18] = '{361,  1,  0, 0, 1, 1, 1, 0};

      // Reset held for 5 clks.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk_reset($sformatf("rst%0d", i));
      end

      // Default instance: pixel rate, hsync window, line wrap.
      release_reset();
      for (int i = 0; i < 15; i++) apply(vec0[i], 0);

      hs_low = 0;
      hs_err = 0;
      for (int i = 0; i < 1600; i++) begin
         step_to(edges + 1);
         if (d0_hs == 1'b0) begin
            hs_low++;
            if (d0_b != 1'b1) hs_err++;
         end
         if (d0_hs != !((d0_h >= 656) && (d0_h <= 751))) hs_err++;
      end
      chk("line_hsync_low_clks", hs_low, 192);
      chk("line_hsync_window_errors", hs_err, 0);
      $display("line monitor hsync_low=%0d errors=%0d", hs_low, hs_err);

      // Small instance: fresh reset, then vsync and frame wrap.
      #3;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk_reset("rst_small");
      release_reset();
      for (int i = 0; i < 19; i++) apply(vec1[i], 1);

      vs_low = 0;
      fs_cnt = 0;
      fs_at  = -1;
      pt_err = 0;
      for (int i = 0; i < 359; i++) begin
         step_to(edges + 1);
         if (d1_vs == 1'b0) vs_low++;
         if (d1_pt != 1'b1) pt_err++;
         if (d1_fs == 1'b1) begin
            fs_cnt++;
            fs_at = edges;
         end
      end
      chk("frame_vsync_low_clks", vs_low, 48);
      chk("frame_start_count", fs_cnt, 1);
      chk("frame_start_edge", fs_at, 720);
      chk("pix_tick_div1_errors", pt_err, 0);
      $display("frame monitor vsync_low=%0d fs_count=%0d fs_edge=%0d", vs_low, fs_cnt, fs_at);

      // Asynchronous reset mid-frame at small-instance (7,5).
      step_to(847);
      chk("pre_async_h", d1_h, 7);
      chk("pre_async_v", d1_v, 5);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset("async");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
      end
      chk_reset("async_hold");

      release_reset();
      found = 0;
      fs_at = -1;
      for (int i = 0; i < 1000 && found == 0; i++) begin
         step_to(edges + 1);
         if (d1_fs == 1'b1) begin
            found = 1;
            fs_at = edges;
         end
      end
      chk("post_reset_first_frame_start", fs_at, 360);
      $display("post-reset first frame_start at edge %0d", fs_at);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
